// File: rtl/chip8_alu_sequencer.sv
// chip8_alu_sequencer
// Initiator side of the CHIP-8 8XYN ALU path: reads Vx/Vy from a synchronous-read
// register file, drives an external combinational ALU, writes the result to Vx and
// the carry/borrow/shift-out flag to VF.
module chip8_alu_sequencer #(
  parameter bit SHIFT_USES_VY  = 1'b0,
  parameter bit VF_RESET_LOGIC = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [15:0] opcode,
  output logic [3:0]  rf_raddr,
  input  logic [7:0]  rf_rdata,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [7:0]  rf_wdata,
  output logic [7:0]  alu_x,
  output logic [7:0]  alu_y,
  output logic [2:0]  alu_op,
  input  logic [7:0]  alu_out,
  input  logic        alu_carry,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_X,
    S_RD_Y,
    S_EXEC,
    S_WB_VX,
    S_WB_VF,
    S_DONE
  } state_t;

  state_t      state_q, state_d;

  logic [3:0]  xAddr_q, yAddr_q;
  logic [2:0]  aluSel_q;
  logic        swap_q, shift_q, logic_q, wantVf_q, err_q;
  logic [7:0]  vx_q, vy_q;
  logic        flag_q;
  logic [7:0]  aluXHold_q, aluYHold_q;
  logic [2:0]  aluOpHold_q;

  logic        decValid, decSwap, decShift, decLogic, decVf;
  logic [2:0]  decOp;
  logic [7:0]  opA, opB;

  // Decode the offered opcode so the accept edge can latch everything the later states need
  always_comb begin
    decValid = 1'b1;
    decOp    = 3'd0;
    decSwap  = 1'b0;
    decShift = 1'b0;
    decLogic = 1'b0;
    decVf    = 1'b0;
    case (opcode[3:0])
      4'h0: decOp = 3'd0;
      4'h1, 4'h2, 4'h3: begin
        decOp    = opcode[2:0];
        decLogic = 1'b1;
        decVf    = VF_RESET_LOGIC;
      end
      4'h4: begin
        decOp = 3'd4;
        decVf = 1'b1;
      end
      4'h5: begin
        decOp = 3'd5;
        decVf = 1'b1;
      end
      4'h6: begin
        decOp    = 3'd6;
        decShift = 1'b1;
        decVf    = 1'b1;
      end
      4'h7: begin
        decOp   = 3'd5;
        decSwap = 1'b1;
        decVf   = 1'b1;
      end
      4'hE: begin
        decOp    = 3'd7;
        decShift = 1'b1;
        decVf    = 1'b1;
      end
      default: decValid = 1'b0;
    endcase
    if (opcode[15:12] != 4'h8) begin
      decValid = 1'b0;
    end
  end

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: fixed one-cycle walk, VF write only for flag-producing ops
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          state_d = decValid ? S_RD_X : S_DONE;
        end
      end
      S_RD_X:  state_d = S_RD_Y;
      S_RD_Y:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB_VX;
      S_WB_VX: state_d = wantVf_q ? S_WB_VF : S_DONE;
      S_WB_VF: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Latch the decoded instruction on accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xAddr_q  <= 4'd0;
      yAddr_q  <= 4'd0;
      aluSel_q <= 3'd0;
      swap_q   <= 1'b0;
      shift_q  <= 1'b0;
      logic_q  <= 1'b0;
      wantVf_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (state_q == S_IDLE && op_valid) begin
      xAddr_q  <= opcode[11:8];
      yAddr_q  <= opcode[7:4];
      aluSel_q <= decOp;
      swap_q   <= decSwap;
      shift_q  <= decShift;
      logic_q  <= decLogic;
      wantVf_q <= decVf;
      err_q    <= ~decValid;
    end
  end

  // Operand capture from the register file, flag capture and ALU-output hold registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vx_q        <= 8'd0;
      vy_q        <= 8'd0;
      flag_q      <= 1'b0;
      aluXHold_q  <= 8'd0;
      aluYHold_q  <= 8'd0;
      aluOpHold_q <= 3'd0;
    end else begin
      if (state_q == S_RD_Y) begin
        vx_q <= rf_rdata;
      end
      if (state_q == S_EXEC) begin
        vy_q <= rf_rdata;
      end
      if (state_q == S_WB_VX) begin
        flag_q      <= alu_carry;
        aluXHold_q  <= opA;
        aluYHold_q  <= opB;
        aluOpHold_q <= aluSel_q;
      end
    end
  end

  // Operand routing: SUBN swaps, shifts optionally take Vy as their source
  always_comb begin
    opA = vx_q;
    opB = vy_q;
    if (swap_q) begin
      opA = vy_q;
      opB = vx_q;
    end else if (shift_q && SHIFT_USES_VY) begin
      opA = vy_q;
    end
  end

  // Outputs decoded from the current state; writes strobe only in the two write-back states
  always_comb begin
    op_ready = (state_q == S_IDLE);
    rf_raddr = 4'd0;
    rf_we    = 1'b0;
    rf_waddr = 4'd0;
    rf_wdata = 8'd0;
    alu_x    = aluXHold_q;
    alu_y    = aluYHold_q;
    alu_op   = aluOpHold_q;
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      S_RD_X: rf_raddr = xAddr_q;
      S_RD_Y: rf_raddr = yAddr_q;
      S_WB_VX: begin
        alu_x    = opA;
        alu_y    = opB;
        alu_op   = aluSel_q;
        rf_we    = 1'b1;
        rf_waddr = xAddr_q;
        rf_wdata = alu_out;
      end
      S_WB_VF: begin
        rf_we    = 1'b1;
        rf_waddr = 4'hF;
        rf_wdata = logic_q ? 8'd0 : {7'b0, flag_q};
      end
      S_DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_chip8_alu_sequencer.sv
// tb_chip8_alu_sequencer
// Random and directed 8XYN instructions against a register-level model of CHIP-8 semantics.
module tb_chip8_alu_sequencer;

  localparam bit SHIFT_VY = 1'b0;
  localparam bit VF_LOGIC = 1'b0;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] opcode;
  logic [3:0]  rf_raddr;
  logic [7:0]  rdataReg;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [7:0]  rf_wdata;
  logic [7:0]  alu_x;
  logic [7:0]  alu_y;
  logic [2:0]  alu_op;
  logic [7:0]  aluOut;
  logic        aluCarry;
  logic        done;
  logic        err;

  typedef struct packed {
    logic       we;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic       done;
    logic       err;
    logic [2:0] aop;
  } exp_t;

  exp_t        expQ[$];
  exp_t        curE;
  logic [7:0]  rf [16];
  logic [7:0]  m [16];
  logic [7:0]  mSave [16];
  logic        pWe;
  logic [3:0]  pAddr;
  logic [7:0]  pData;
  logic [2:0]  modelAluOp;
  logic [3:0]  nList [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hE, 4'h8, 4'h9, 4'hF};
  int          total;
  int          bad;
  int          negCount;
  int          acceptNeg;
  int          doneLat;

  chip8_alu_sequencer #(
    .SHIFT_USES_VY (SHIFT_VY),
    .VF_RESET_LOGIC(VF_LOGIC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .opcode   (opcode),
    .rf_raddr (rf_raddr),
    .rf_rdata (rdataReg),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .alu_x    (alu_x),
    .alu_y    (alu_y),
    .alu_op   (alu_op),
    .alu_out  (aluOut),
    .alu_carry(aluCarry),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational ALU
  always_comb begin
    aluOut   = 8'd0;
    aluCarry = 1'b0;
    case (alu_op)
      3'd0: aluOut = alu_y;
      3'd1: aluOut = alu_x | alu_y;
      3'd2: aluOut = alu_x & alu_y;
      3'd3: aluOut = alu_x ^ alu_y;
      3'd4: {aluCarry, aluOut} = {1'b0, alu_x} + {1'b0, alu_y};
      3'd5: begin
        aluOut   = alu_x - alu_y;
        aluCarry = alu_x > alu_y;
      end
      3'd6: begin
        aluOut   = alu_x >> 1;
        aluCarry = alu_x[0];
      end
      default: begin
        aluOut   = alu_x << 1;
        aluCarry = alu_x[7];
      end
    endcase
  end

  // Synchronous-read register file with a bench-side preload port
  always @(posedge clk) begin
    rdataReg <= rf[rf_raddr];
    if (pWe) begin
      rf[pAddr] <= pData;
    end else if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Per-cycle compare against the expected timeline, or idle behaviour when none is pending
  always @(negedge clk) begin
    negCount++;
    if (!reset) begin
      if (done === 1'b1) begin
        doneLat = negCount - acceptNeg;
      end
      if (expQ.size() > 0) begin
        curE = expQ.pop_front();
        checkOutput("rf_we", {15'd0, rf_we}, {15'd0, curE.we});
        if (curE.we) begin
          checkOutput("rf_waddr", {12'd0, rf_waddr}, {12'd0, curE.waddr});
          checkOutput("rf_wdata", {8'd0, rf_wdata}, {8'd0, curE.wdata});
        end
        checkOutput("done", {15'd0, done}, {15'd0, curE.done});
        checkOutput("err", {15'd0, err}, {15'd0, curE.err});
        checkOutput("busy_ready", {15'd0, op_ready}, 16'd0);
        checkOutput("alu_op", {13'd0, alu_op}, {13'd0, curE.aop});
      end else begin
        checkOutput("idle_we", {15'd0, rf_we}, 16'd0);
        checkOutput("idle_done", {15'd0, done}, 16'd0);
        checkOutput("idle_ready", {15'd0, op_ready}, 16'd1);
        checkOutput("idle_alu_op", {13'd0, alu_op}, {13'd0, modelAluOp});
      end
    end
  end

  // CHIP-8 semantics: compute the result, flag and expected cycle-by-cycle timeline
  task automatic modelOp(input logic [15:0] op);
    logic [3:0] x, y;
    logic [7:0] vx, vy, src, res;
    logic       flag, vf, valid;
    logic [2:0] aop;
    int         s;
    exp_t       e;
    x     = op[11:8];
    y     = op[7:4];
    vx    = m[x];
    vy    = m[y];
    src   = SHIFT_VY ? vy : vx;
    valid = (op[15:12] == 4'h8);
    vf    = 1'b1;
    flag  = 1'b0;
    res   = 8'd0;
    aop   = 3'd0;
    case (op[3:0])
      4'h0: begin res = vy; vf = 1'b0; aop = 3'd0; end
      4'h1: begin res = vx | vy; vf = VF_LOGIC; aop = 3'd1; end
      4'h2: begin res = vx & vy; vf = VF_LOGIC; aop = 3'd2; end
      4'h3: begin res = vx ^ vy; vf = VF_LOGIC; aop = 3'd3; end
      4'h4: begin s = int'(vx) + int'(vy); res = 8'(s); flag = (s > 255); aop = 3'd4; end
      4'h5: begin res = 8'(int'(vx) - int'(vy)); flag = (vx > vy); aop = 3'd5; end
      4'h7: begin res = 8'(int'(vy) - int'(vx)); flag = (vy > vx); aop = 3'd5; end
      4'h6: begin res = src / 2; flag = src[0]; aop = 3'd6; end
      4'hE: begin res = 8'(int'(src) * 2); flag = src[7]; aop = 3'd7; end
      default: valid = 1'b0;
    endcase
    if (!valid) begin
      e = '{we: 1'b0, waddr: 4'd0, wdata: 8'd0, done: 1'b1, err: 1'b1, aop: modelAluOp};
      expQ.push_back(e);
    end else begin
      for (int k = 0; k < 3; k++) begin
        e = '{we: 1'b0, waddr: 4'd0, wdata: 8'd0, done: 1'b0, err: 1'b0, aop: modelAluOp};
        expQ.push_back(e);
      end
      e = '{we: 1'b1, waddr: x, wdata: res, done: 1'b0, err: 1'b0, aop: aop};
      expQ.push_back(e);
      m[x] = res;
      if (vf) begin
        e = '{we: 1'b1, waddr: 4'hF, wdata: {7'b0, flag}, done: 1'b0, err: 1'b0, aop: aop};
        expQ.push_back(e);
        m[15] = {7'b0, flag};
      end
      e = '{we: 1'b0, waddr: 4'd0, wdata: 8'd0, done: 1'b1, err: 1'b0, aop: aop};
      expQ.push_back(e);
      modelAluOp = aop;
    end
  endtask

  task automatic loadReg(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk);
    #1 pWe = 1'b1;
    pAddr = a;
    pData = d;
    @(posedge clk);
    #1 pWe = 1'b0;
    m[a] = d;
  endtask

  // Offer one opcode, model it at the accept edge, jam ignored offers while busy
  task automatic applyStimulus(input logic [15:0] op);
    int len;
    int guard;
    doneLat = -1;
    @(posedge clk);
    #1 op_valid = 1'b1;
    opcode = op;
    @(posedge clk);
    acceptNeg = negCount;
    modelOp(op);
    len = expQ.size();
    for (int k = 1; k < len; k++) begin
      #1 op_valid = 1'($urandom_range(0, 1));
      opcode = 16'($urandom);
      @(posedge clk);
    end
    #1 op_valid = 1'b0;
    guard = 0;
    while (expQ.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
  endtask

  function automatic logic [15:0] randOp();
    logic [3:0] hi;
    hi = ($urandom_range(0, 9) == 0) ? 4'h9 : 4'h8;
    return {hi, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), nList[$urandom_range(0, 11)]};
  endfunction

  initial begin
    total      = 0;
    bad        = 0;
    negCount   = 0;
    acceptNeg  = 0;
    doneLat    = -1;
    modelAluOp = 3'd0;
    reset      = 1'b1;
    op_valid   = 1'b0;
    opcode     = 16'd0;
    pWe        = 1'b0;
    pAddr      = 4'd0;
    pData      = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", {15'd0, op_ready}, 16'd1);
    checkOutput("rst_done", {15'd0, done}, 16'd0);
    checkOutput("rst_err", {15'd0, err}, 16'd0);
    checkOutput("rst_we", {15'd0, rf_we}, 16'd0);
    checkOutput("rst_raddr", {12'd0, rf_raddr}, 16'd0);
    checkOutput("rst_waddr", {12'd0, rf_waddr}, 16'd0);
    checkOutput("rst_wdata", {8'd0, rf_wdata}, 16'd0);
    checkOutput("rst_alu_x", {8'd0, alu_x}, 16'd0);
    checkOutput("rst_alu_y", {8'd0, alu_y}, 16'd0);
    checkOutput("rst_alu_op", {13'd0, alu_op}, 16'd0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      loadReg(4'(i), 8'($urandom));
    end

    loadReg(4'h3, 8'hFF);
    loadReg(4'h4, 8'h01);
    applyStimulus(16'h8344);
    checkOutput("add_v3", {8'd0, rf[3]}, 16'h0000);
    checkOutput("add_vf", {8'd0, rf[15]}, 16'h0001);
    checkOutput("add_lat", 16'(doneLat), 16'd6);

    loadReg(4'h3, 8'h05);
    loadReg(4'h4, 8'h05);
    applyStimulus(16'h8345);
    checkOutput("sub_eq_v3", {8'd0, rf[3]}, 16'h0000);
    checkOutput("sub_eq_vf", {8'd0, rf[15]}, 16'h0000);
    loadReg(4'h3, 8'h02);
    loadReg(4'h4, 8'h07);
    applyStimulus(16'h8347);
    checkOutput("subn_v3", {8'd0, rf[3]}, 16'h0005);
    checkOutput("subn_vf", {8'd0, rf[15]}, 16'h0001);

    loadReg(4'h2, 8'h81);
    applyStimulus(16'h826E);
    checkOutput("shl_v2", {8'd0, rf[2]}, 16'h0002);
    checkOutput("shl_vf", {8'd0, rf[15]}, 16'h0001);
    loadReg(4'h2, 8'h81);
    applyStimulus(16'h8266);
    checkOutput("shr_v2", {8'd0, rf[2]}, 16'h0040);
    checkOutput("shr_vf", {8'd0, rf[15]}, 16'h0001);

    loadReg(4'hF, 8'h55);
    loadReg(4'h1, 8'hF0);
    loadReg(4'h2, 8'h0F);
    applyStimulus(16'h8121);
    checkOutput("or_v1", {8'd0, rf[1]}, 16'h00FF);
    checkOutput("or_vf", {8'd0, rf[15]}, 16'h0055);
    checkOutput("or_lat", 16'(doneLat), 16'd5);

    loadReg(4'hF, 8'h10);
    loadReg(4'h0, 8'h20);
    applyStimulus(16'h8F04);
    checkOutput("xf_vf", {8'd0, rf[15]}, 16'h0000);
    checkOutput("xf_lat", 16'(doneLat), 16'd6);
    applyStimulus(16'h9120);
    checkOutput("bad_lat", 16'(doneLat), 16'd1);

    for (int i = 0; i < 150; i++) begin
      if (i % 8 == 0) begin
        loadReg(4'($urandom_range(0, 15)), 8'($urandom));
      end
      applyStimulus(randOp());
    end

    // Reset in the middle of the Vx write must leave the register file untouched
    mSave = m;
    @(posedge clk);
    #1 op_valid = 1'b1;
    opcode = 16'h8124;
    @(posedge clk);
    acceptNeg = negCount;
    modelOp(16'h8124);
    #1 op_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1 checkOutput("wbvx_we", {15'd0, rf_we}, 16'd1);
    #1 reset = 1'b1;
    expQ.delete();
    m = mSave;
    modelAluOp = 3'd0;
    #1;
    checkOutput("midrst_we", {15'd0, rf_we}, 16'd0);
    checkOutput("midrst_ready", {15'd0, op_ready}, 16'd1);
    checkOutput("midrst_done", {15'd0, done}, 16'd0);
    checkOutput("midrst_alu_op", {13'd0, alu_op}, 16'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 30; i++) begin
      applyStimulus(randOp());
    end
    applyStimulus(16'h8124);

    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("final_v%0d", i), {8'd0, rf[i]}, {8'd0, m[i]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
